// File: rtl/pkt_pkg.sv
// Shared definitions for the packet sequence checker: state codes, the
// default header word and the elaboration-time width sanity check.
package pkt_pkg;

  // Externally visible state codes; the encoding is part of the interface.
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FIRST_PKT = 3'd1,
    ST_REG_PKT   = 3'd2,
    ST_F_ERR     = 3'd3,
    ST_SEQ_ERR   = 3'd4
  } state_e;

  // Default configuration: 16-bit bus of four 4-bit words, header all ones.
  localparam int         DEF_BUS_SIZE  = 32'sd16;
  localparam int         DEF_WORD_SIZE = 32'sd4;
  localparam logic [3:0] DEF_HEADER    = 4'hF;

  // True when the bus splits evenly into at least two words.
  function automatic bit widths_ok(input int bus_size, input int word_size,
                                   input int word_num);
    if (word_size <= 32'sd0) begin
      return 1'b0;
    end else begin
      return ((bus_size % word_size) == 32'sd0) &&
             (word_num == (bus_size / word_size)) &&
             (word_num >= 32'sd2);
    end
  endfunction

  // Both error codes share the same "error flag set" meaning.
  function automatic logic is_err_state(input state_e s);
    return (s == ST_F_ERR) || (s == ST_SEQ_ERR);
  endfunction

endpackage

// File: rtl/word_split.sv
// Slices a packet bus into its words and flags which words are non-zero.
module word_split
  import pkt_pkg::*;
#(
  parameter int BUS_SIZE  = DEF_BUS_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE
) (
  input  logic [BUS_SIZE-1:0]                 i_bus,
  output logic [WORD_NUM-1:0][WORD_SIZE-1:0]  o_words,
  output logic [WORD_NUM-1:0]                 o_nonzero
);

  for (genvar g = 0; g < WORD_NUM; g++) begin : g_word
    assign o_words[g]   = i_bus[g*WORD_SIZE +: WORD_SIZE];
    assign o_nonzero[g] = |i_bus[g*WORD_SIZE +: WORD_SIZE];
  end

endmodule

// File: rtl/pkt_seq_checker.sv
// Packet sequence checker: validates the header word (most-significant word)
// and the sequence word (word 0) of each valid packet, reports a registered
// error flag and state code, and forwards accepted packets with per-word
// non-zero flags. All outputs are registered.
// Optional: define PKT_SEQ_CHECKER_ERR_COUNT_EN to add the saturating
// err_count output.
module pkt_seq_checker
  import pkt_pkg::*;
#(
  parameter int                   BUS_SIZE     = DEF_BUS_SIZE,
  parameter int                   WORD_SIZE    = DEF_WORD_SIZE,
  parameter int                   WORD_NUM     = BUS_SIZE / WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] HEADER       = {WORD_SIZE{1'b1}},
  parameter bit                   STRICT_START = 1'b0,
  parameter bit                   RECOVER      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [BUS_SIZE-1:0]  data_bus,
  output logic                 error,
  output logic [2:0]           state,
  output logic [BUS_SIZE-1:0]  data_out_bus,
  output logic                 out_valid,
  output logic [WORD_NUM-1:0]  control_out,
  output logic [WORD_SIZE-1:0] pkt_count
`ifdef PKT_SEQ_CHECKER_ERR_COUNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  if (!widths_ok(BUS_SIZE, WORD_SIZE, WORD_NUM)) begin : g_bad_widths
    $fatal(1, "pkt_seq_checker: BUS_SIZE must be a multiple of WORD_SIZE giving at least two words");
  end

  localparam logic [WORD_SIZE-1:0] SEQ_ONE = WORD_SIZE'(1'b1);

  state_e                              r_state;
  state_e                              w_state_nxt;
  logic                                r_error;
  logic                                r_out_valid;
  logic [BUS_SIZE-1:0]                 r_data_out;
  logic [WORD_NUM-1:0]                 r_control;
  logic [WORD_SIZE-1:0]                r_pkt_count;
  logic [WORD_SIZE-1:0]                r_exp_seq;

  logic [WORD_NUM-1:0][WORD_SIZE-1:0]  w_words;
  logic [WORD_NUM-1:0]                 w_nonzero;
  logic [WORD_SIZE-1:0]                w_hdr;
  logic [WORD_SIZE-1:0]                w_seq;
  logic                                w_hdr_ok;
  logic                                w_seq_bad;
  logic                                w_accept;
  logic                                w_reject;

  word_split #(
    .BUS_SIZE  (BUS_SIZE),
    .WORD_SIZE (WORD_SIZE),
    .WORD_NUM  (WORD_NUM)
  ) u_word_split (
    .i_bus     (data_bus),
    .o_words   (w_words),
    .o_nonzero (w_nonzero)
  );

  assign w_hdr    = w_words[WORD_NUM-1];
  assign w_seq    = w_words[0];
  assign w_hdr_ok = (w_hdr == HEADER);

  // Sequence is wrong in REG_PKT on any mismatch; in FIRST_PKT only when a
  // strict start is required and the packet does not carry sequence 0.
  assign w_seq_bad = (r_state == ST_REG_PKT) ? (w_seq != r_exp_seq)
                                             : (STRICT_START && (w_seq != {WORD_SIZE{1'b0}}));

  // Next-state decode: header check has priority over the sequence check.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_FIRST_PKT;
      end
      ST_FIRST_PKT, ST_REG_PKT: begin
        if (valid) begin
          if (!w_hdr_ok) begin
            w_state_nxt = ST_F_ERR;
            w_reject    = 1'b1;
          end else if (w_seq_bad) begin
            w_state_nxt = ST_SEQ_ERR;
            w_reject    = 1'b1;
          end else begin
            w_state_nxt = ST_REG_PKT;
            w_accept    = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_F_ERR, ST_SEQ_ERR: begin
        // Resync on any good header regardless of sequence; sticky otherwise.
        if (valid && RECOVER) begin
          if (w_hdr_ok) begin
            w_state_nxt = ST_REG_PKT;
            w_accept    = 1'b1;
          end else begin
            w_state_nxt = ST_F_ERR;
            w_reject    = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  // State, flags, forwarded packet and counters, all updated on the clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RESET;
      r_error     <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= {BUS_SIZE{1'b0}};
      r_control   <= {WORD_NUM{1'b0}};
      r_pkt_count <= {WORD_SIZE{1'b0}};
      r_exp_seq   <= {WORD_SIZE{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_error     <= is_err_state(w_state_nxt);
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_data_out  <= data_bus;
        r_control   <= w_nonzero;
        r_pkt_count <= r_pkt_count + SEQ_ONE;
        r_exp_seq   <= w_seq + SEQ_ONE;
      end
    end
  end

`ifdef PKT_SEQ_CHECKER_ERR_COUNT_EN
  logic [7:0] r_err_count;

  // Count every rejected packet, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= 8'h00;
    end else if (w_reject && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'h01;
    end
  end

  assign err_count = r_err_count;
`endif

  assign state        = r_state;
  assign error        = r_error;
  assign out_valid    = r_out_valid;
  assign data_out_bus = r_data_out;
  assign control_out  = r_control;
  assign pkt_count    = r_pkt_count;

endmodule

// File: tb/tb_pkt_seq_checker.sv
// Self-checking bench for pkt_seq_checker (16/4, header F). Three instances
// share one stimulus stream: [0] STRICT_START=0/RECOVER=1,
// [1] STRICT_START=0/RECOVER=0, [2] STRICT_START=1/RECOVER=1.
module tb_pkt_seq_checker;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [15:0] data_bus;

  logic [2:0]  o_state [NI];
  logic        o_error [NI];
  logic [15:0] o_dout  [NI];
  logic        o_ov    [NI];
  logic [3:0]  o_ctl   [NI];
  logic [3:0]  o_cnt   [NI];
`ifdef PKT_SEQ_CHECKER_ERR_COUNT_EN
  logic [7:0]  o_ecnt  [NI];
`endif

  // Reference model: one record per instance, driven by the packet rules.
  int          m_st   [NI];
  logic        m_err  [NI];
  logic        m_ov   [NI];
  logic [15:0] m_dout [NI];
  logic [3:0]  m_ctl  [NI];
  logic [3:0]  m_cnt  [NI];
  logic [3:0]  m_exp  [NI];
  int          m_ecnt [NI];
  bit          p_strict [NI] = '{1'b0, 1'b0, 1'b1};
  bit          p_rec    [NI] = '{1'b1, 1'b0, 1'b1};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pkt_seq_checker #(
      .BUS_SIZE     (16),
      .WORD_SIZE    (4),
      .HEADER       (4'hF),
      .STRICT_START ((g == 2) ? 1'b1 : 1'b0),
      .RECOVER      ((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .valid        (valid),
      .data_bus     (data_bus),
      .error        (o_error[g]),
      .state        (o_state[g]),
      .data_out_bus (o_dout[g]),
      .out_valid    (o_ov[g]),
      .control_out  (o_ctl[g]),
      .pkt_count    (o_cnt[g])
`ifdef PKT_SEQ_CHECKER_ERR_COUNT_EN
      ,
      .err_count    (o_ecnt[g])
`endif
    );
  end

  task automatic model_update();
    logic [3:0] hdr;
    logic [3:0] seq;
    bit acc;
    bit rej;
    hdr = data_bus[15:12];
    seq = data_bus[3:0];
    for (int k = 0; k < NI; k++) begin
      acc = 1'b0;
      rej = 1'b0;
      if (reset) begin
        m_st[k] = 0; m_ov[k] = 1'b0; m_dout[k] = 16'h0; m_ctl[k] = 4'h0;
        m_cnt[k] = 4'h0; m_exp[k] = 4'h0; m_ecnt[k] = 0;
      end else begin
        m_ov[k] = 1'b0;
        if (m_st[k] == 0) begin
          m_st[k] = 1;
        end else if (valid) begin
          if (m_st[k] == 1 || m_st[k] == 2) begin
            if (hdr != 4'hF) begin
              m_st[k] = 3; rej = 1'b1;
            end else if ((m_st[k] == 2 && seq != m_exp[k]) ||
                         (m_st[k] == 1 && p_strict[k] && seq != 4'h0)) begin
              m_st[k] = 4; rej = 1'b1;
            end else begin
              acc = 1'b1;
            end
          end else if (p_rec[k]) begin
            if (hdr == 4'hF) acc = 1'b1;
            else begin m_st[k] = 3; rej = 1'b1; end
          end
        end
        if (acc) begin
          m_st[k] = 2;
          m_exp[k] = seq + 4'd1;
          m_cnt[k] = m_cnt[k] + 4'd1;
          m_dout[k] = data_bus;
          m_ov[k] = 1'b1;
          for (int w = 0; w < 4; w++) m_ctl[k][w] = (((data_bus >> (4 * w)) & 16'hF) != 16'h0);
        end
        if (rej && m_ecnt[k] < 255) m_ecnt[k] = m_ecnt[k] + 1;
      end
      m_err[k] = (m_st[k] == 3 || m_st[k] == 4);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic r, input logic v, input logic [15:0] d);
    reset = r; valid = v; data_bus = d;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 16'hF000);
    cyc(1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_error[k], o_ov[k], o_dout[k], o_ctl[k], o_cnt[k]} !== {3'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0}) begin
        n_err++;
        $display("FAIL reset_values dut%0d got st=%0d err=%b ov=%b dout=%h ctl=%b cnt=%0d want all zero",
                 k, o_state[k], o_error[k], o_ov[k], o_dout[k], o_ctl[k], o_cnt[k]);
      end
    end
    cyc(1'b0, 1'b1, 16'hF000);  // valid ignored while leaving RESET
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_ov[k], o_cnt[k]} !== {3'd1, 1'b0, 4'h0}) begin
        n_err++;
        $display("FAIL reset_exit dut%0d got st=%0d ov=%b cnt=%0d want st=1 ov=0 cnt=0",
                 k, o_state[k], o_ov[k], o_cnt[k]);
      end
    end
  endtask

  task automatic test_basic();
    int pulses [NI] = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'hF000 | 16'(i));
      for (int k = 0; k < NI; k++) pulses[k] += int'(o_ov[k]);
    end
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_error[k], o_cnt[k], o_dout[k], o_ctl[k]} !== {3'd2, 1'b0, 4'd3, 16'hF002, 4'b1001}) begin
        n_err++;
        $display("FAIL basic_accept dut%0d got st=%0d err=%b cnt=%0d dout=%h ctl=%b want 2 0 3 F002 1001",
                 k, o_state[k], o_error[k], o_cnt[k], o_dout[k], o_ctl[k]);
      end
      n_vec++;
      if (pulses[k] !== 3) begin
        n_err++;
        $display("FAIL basic_pulses dut%0d got %0d want 3", k, pulses[k]);
      end
    end
    cyc(1'b0, 1'b0, 16'hF003);  // idle: nothing checked, nothing forwarded
    n_vec++;
    if ({o_ov[0], o_state[0], o_cnt[0]} !== {1'b0, 3'd2, 4'd3}) begin
      n_err++;
      $display("FAIL idle_hold got ov=%b st=%0d cnt=%0d want 0 2 3", o_ov[0], o_state[0], o_cnt[0]);
    end
  endtask

  task automatic test_wrap();
    for (int s = 3; s < 16; s++) cyc(1'b0, 1'b1, 16'hF000 | 16'(s));
    cyc(1'b0, 1'b1, 16'hF000);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_error[k], o_dout[k], o_cnt[k], o_ov[k]} !== {3'd2, 1'b0, 16'hF000, 4'd1, 1'b1}) begin
        n_err++;
        $display("FAIL seq_wrap dut%0d got st=%0d err=%b dout=%h cnt=%0d ov=%b want 2 0 F000 1 1",
                 k, o_state[k], o_error[k], o_dout[k], o_cnt[k], o_ov[k]);
      end
    end
    cyc(1'b0, 1'b1, 16'hF005);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_error[k], o_dout[k], o_ov[k]} !== {3'd4, 1'b1, 16'hF000, 1'b0}) begin
        n_err++;
        $display("FAIL seq_err dut%0d got st=%0d err=%b dout=%h ov=%b want 4 1 F000 0",
                 k, o_state[k], o_error[k], o_dout[k], o_ov[k]);
      end
    end
  endtask

  task automatic test_header_err();
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'hF000);
    cyc(1'b0, 1'b1, 16'h7003);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_error[k], o_ov[k]} !== {3'd3, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL hdr_err dut%0d got st=%0d err=%b ov=%b want 3 1 0", k, o_state[k], o_error[k], o_ov[k]);
      end
    end
    cyc(1'b0, 1'b1, 16'hF009);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_error[k]} !== (p_rec[k] ? {3'd2, 1'b0} : {3'd3, 1'b1})) begin
        n_err++;
        $display("FAIL recover dut%0d got st=%0d err=%b recover=%0d", k, o_state[k], o_error[k], p_rec[k]);
      end
    end
    cyc(1'b0, 1'b1, 16'hF00A);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_cnt[k]} !== (p_rec[k] ? {3'd2, 4'd3} : {3'd3, 4'd1})) begin
        n_err++;
        $display("FAIL resync_seq dut%0d got st=%0d cnt=%0d", k, o_state[k], o_cnt[k]);
      end
    end
    cyc(1'b0, 1'b1, 16'h1234);
    n_vec++;
    if ({o_state[0], o_error[0], o_dout[0]} !== {3'd3, 1'b1, 16'hF00A}) begin
      n_err++;
      $display("FAIL both_faults got st=%0d err=%b dout=%h want 3 1 F00A", o_state[0], o_error[0], o_dout[0]);
    end
  endtask

  task automatic test_strict();
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'hF003);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (o_state[k] !== (p_strict[k] ? 3'd4 : 3'd2)) begin
        n_err++;
        $display("FAIL strict_first dut%0d got st=%0d strict=%0d", k, o_state[k], p_strict[k]);
      end
    end
    cyc(1'b0, 1'b1, 16'hF004);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_cnt[k]} !== {3'd2, (p_strict[k] ? 4'd1 : 4'd2)}) begin
        n_err++;
        $display("FAIL strict_next dut%0d got st=%0d cnt=%0d", k, o_state[k], o_cnt[k]);
      end
    end
  endtask

  task automatic test_reset_in_err();
    cyc(1'b0, 1'b1, 16'hF007);
    n_vec++;
    if (o_state[0] !== 3'd4) begin
      n_err++;
      $display("FAIL pre_reset_seq_err got st=%0d want 4", o_state[0]);
    end
    cyc(1'b1, 1'b1, 16'hF000);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_error[k], o_cnt[k], o_ov[k], o_dout[k]} !== {3'd0, 1'b0, 4'd0, 1'b0, 16'h0}) begin
        n_err++;
        $display("FAIL reset_in_err dut%0d got st=%0d err=%b cnt=%0d ov=%b dout=%h want all zero",
                 k, o_state[k], o_error[k], o_cnt[k], o_ov[k], o_dout[k]);
      end
    end
  endtask

  task automatic test_err_sat();
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'hF000);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 16'h0123);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if ({o_state[k], o_error[k]} !== {3'd3, 1'b1}) begin
        n_err++;
        $display("FAIL bad_hdr_run dut%0d got st=%0d err=%b want 3 1", k, o_state[k], o_error[k]);
      end
`ifdef PKT_SEQ_CHECKER_ERR_COUNT_EN
      n_vec++;
      if (o_ecnt[k] !== (p_rec[k] ? 8'hFF : 8'h01)) begin
        n_err++;
        $display("FAIL err_count_sat dut%0d got %h want %h", k, o_ecnt[k], (p_rec[k] ? 8'hFF : 8'h01));
      end
`endif
    end
    cyc(1'b1, 1'b0, 16'h0000);
`ifdef PKT_SEQ_CHECKER_ERR_COUNT_EN
    n_vec++;
    if (o_ecnt[0] !== 8'h00) begin
      n_err++;
      $display("FAIL err_count_reset got %h want 00", o_ecnt[0]);
    end
`endif
  endtask

  task automatic test_random();
    logic r;
    logic v;
    logic [3:0] hdr;
    logic [3:0] seq;
    logic [7:0] mid;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 9) < 7);
      hdr = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      seq = ($urandom_range(0, 9) < 7) ? m_exp[i % NI] : 4'($urandom);
      mid = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cyc(r, v, {hdr, mid, seq});
      for (int k = 0; k < NI; k++) begin
        n_vec++;
        if ({o_state[k], o_error[k], o_ov[k], o_dout[k], o_ctl[k], o_cnt[k]} !==
            {3'(m_st[k]), m_err[k], m_ov[k], m_dout[k], m_ctl[k], m_cnt[k]}) begin
          n_err++;
          $display("FAIL random dut%0d cyc%0d got st=%0d err=%b ov=%b dout=%h ctl=%b cnt=%0d want st=%0d err=%b ov=%b dout=%h ctl=%b cnt=%0d",
                   k, i, o_state[k], o_error[k], o_ov[k], o_dout[k], o_ctl[k], o_cnt[k],
                   m_st[k], m_err[k], m_ov[k], m_dout[k], m_ctl[k], m_cnt[k]);
        end
`ifdef PKT_SEQ_CHECKER_ERR_COUNT_EN
        n_vec++;
        if (o_ecnt[k] !== 8'(m_ecnt[k])) begin
          n_err++;
          $display("FAIL random_errcnt dut%0d cyc%0d got %0d want %0d", k, i, o_ecnt[k], m_ecnt[k]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_header_err();
    test_strict();
    test_reset_in_err();
    test_err_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
